// File: rtl/pdh_cmd_regbank.sv
// PS-to-PL command interface with a shadow/active register bank.
// A rising edge on the synchronised PS strobe latches one command word.
// The command executes in the following cycle. That cycle updates the banks,
// writes the callback word and toggles the ack bit. The datapath only ever
// sees the active bank, and the active bank changes only in that execute
// cycle, so every update reaches the datapath as one coherent image.
//
// Handshake: the PS raises bit 30 with bits [29:0] already stable. It holds
// those bits until it sees the callback ack bit toggle, then drops the strobe.
// Only the rising strobe edge carries meaning. A further rising edge that
// lands while a command is executing is discarded and recorded in the sticky
// overrun flag.
module pdh_cmd_regbank #(
  parameter int GPIO_WIDTH  = 32,
  parameter int SYNC_STAGES = 2,
  parameter int NUM_REGS    = 16,
  parameter int ADDR_BITS   = 4,
  parameter int REG_WIDTH   = 16,
  parameter logic [NUM_REGS*REG_WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [GPIO_WIDTH-1:0]         axi_from_ps_i,
  output logic [GPIO_WIDTH-1:0]         axi_to_ps_o,
  output logic [NUM_REGS*REG_WIDTH-1:0] regs_o,
  output logic                          commit_o,
  output logic                          busy_o
);

  localparam logic [3:0] OP_NOP        = 4'd0;
  localparam logic [3:0] OP_WR_SHADOW  = 4'd1;
  localparam logic [3:0] OP_RD_SHADOW  = 4'd2;
  localparam logic [3:0] OP_RD_ACTIVE  = 4'd3;
  localparam logic [3:0] OP_COMMIT     = 4'd4;
  localparam logic [3:0] OP_WR_DIRECT  = 4'd5;
  localparam logic [3:0] OP_REVERT     = 4'd6;
  localparam logic [3:0] OP_CLR_STATUS = 4'd7;

  localparam logic [ADDR_BITS:0] NUM_REGS_W = NUM_REGS[ADDR_BITS:0];

  typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                   dly_r;
  logic                   edge_w;
  logic                   latch_cmd;
  logic                   exec;

  logic [3:0]             cmd_op_r;
  logic [ADDR_BITS-1:0]   cmd_addr_r;
  logic [REG_WIDTH-1:0]   cmd_data_r;

  logic                   ack_r;
  logic                   overrun_r;
  logic                   commit_r;
  logic [GPIO_WIDTH-1:0]  cb_r;

  logic [REG_WIDTH-1:0]   shadow_r [NUM_REGS];
  logic [REG_WIDTH-1:0]   active_r [NUM_REGS];

  // Decoded effect of the latched command
  logic                   addr_ok;
  logic [ADDR_BITS-1:0]   addr_idx;
  logic                   err;
  logic [REG_WIDTH-1:0]   rd_data;
  logic                   wr_shadow;
  logic                   wr_active;
  logic                   do_commit;
  logic                   do_revert;
  logic                   ovr_next;
  logic [GPIO_WIDTH-1:0]  cb_next;

  // Bits of the PS word that carry no command field
  logic unused_ps_bits;
  assign unused_ps_bits = &{1'b0, axi_from_ps_i[GPIO_WIDTH-1:31],
                            axi_from_ps_i[25-ADDR_BITS:REG_WIDTH]};

  // Strobe synchroniser chain plus the edge-delay flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= '0;
      dly_r  <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], axi_from_ps_i[30]};
      dly_r  <= sync_r[SYNC_STAGES-1];
    end
  end

  assign edge_w = sync_r[SYNC_STAGES-1] & ~dly_r;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: accept an edge in IDLE, execute for exactly one cycle
  always_comb begin
    state_d   = state_q;
    latch_cmd = 1'b0;
    exec      = 1'b0;
    case (state_q)
      IDLE: begin
        if (edge_w) begin
          latch_cmd = 1'b1;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        exec    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q == EXEC);

  // Command latch, captured on the accepted strobe edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_op_r   <= '0;
      cmd_addr_r <= '0;
      cmd_data_r <= '0;
    end else if (latch_cmd) begin
      cmd_op_r   <= axi_from_ps_i[29:26];
      cmd_addr_r <= axi_from_ps_i[25:26-ADDR_BITS];
      cmd_data_r <= axi_from_ps_i[REG_WIDTH-1:0];
    end
  end

  // Opcode decode, address check and callback word assembly
  always_comb begin
    addr_ok   = ({1'b0, cmd_addr_r} < NUM_REGS_W);
    addr_idx  = addr_ok ? cmd_addr_r : '0;
    err       = 1'b0;
    rd_data   = '0;
    wr_shadow = 1'b0;
    wr_active = 1'b0;
    do_commit = 1'b0;
    do_revert = 1'b0;
    ovr_next  = overrun_r;
    case (cmd_op_r)
      OP_NOP: ;
      OP_WR_SHADOW: begin
        if (addr_ok) begin
          wr_shadow = 1'b1;
          rd_data   = cmd_data_r;
        end else begin
          err = 1'b1;
        end
      end
      OP_RD_SHADOW: begin
        if (addr_ok) rd_data = shadow_r[addr_idx];
        else         err     = 1'b1;
      end
      OP_RD_ACTIVE: begin
        if (addr_ok) rd_data = active_r[addr_idx];
        else         err     = 1'b1;
      end
      OP_COMMIT: do_commit = 1'b1;
      OP_WR_DIRECT: begin
        if (addr_ok) begin
          wr_shadow = 1'b1;
          wr_active = 1'b1;
          rd_data   = cmd_data_r;
        end else begin
          err = 1'b1;
        end
      end
      OP_REVERT:     do_revert = 1'b1;
      OP_CLR_STATUS: ovr_next  = 1'b0;
      default:       err       = 1'b1;
    endcase
    // An edge seen while executing is a dropped command
    ovr_next = ovr_next | edge_w;

    cb_next                         = '0;
    cb_next[31]                     = ~ack_r;
    cb_next[30]                     = err;
    cb_next[29]                     = ovr_next;
    cb_next[28:25]                  = cmd_op_r;
    cb_next[REG_WIDTH +: ADDR_BITS] = cmd_addr_r;
    cb_next[REG_WIDTH-1:0]          = rd_data;
  end

  // Status, ack toggle, callback and commit pulse, all written by EXEC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_r     <= 1'b0;
      overrun_r <= 1'b0;
      cb_r      <= '0;
      commit_r  <= 1'b0;
    end else begin
      commit_r <= exec & (do_commit | wr_active);
      if (exec) begin
        ack_r     <= ~ack_r;
        overrun_r <= ovr_next;
        cb_r      <= cb_next;
      end
    end
  end

  // Shadow and active banks; bulk copies and single writes happen only in EXEC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_r[i] <= RESET_VAL[i*REG_WIDTH +: REG_WIDTH];
        active_r[i] <= RESET_VAL[i*REG_WIDTH +: REG_WIDTH];
      end
    end else if (exec) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (do_commit) active_r[i] <= shadow_r[i];
        if (do_revert) shadow_r[i] <= active_r[i];
      end
      if (wr_shadow) shadow_r[addr_idx] <= cmd_data_r;
      if (wr_active) active_r[addr_idx] <= cmd_data_r;
    end
  end

  // Flatten the active bank onto the datapath bus
  always_comb begin
    regs_o = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_o[i*REG_WIDTH +: REG_WIDTH] = active_r[i];
    end
  end

  assign axi_to_ps_o = cb_r;
  assign commit_o    = commit_r;

endmodule
